// File: rtl/decoder24_pkg.sv
// decoder24_pkg: shared types, FSM states and the 2-to-4 decode function
package decoder24_pkg;
   typedef logic [1:0] code_t;
   typedef logic [3:0] onehot_t;
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} st_t;
   localparam onehot_t ONEHOT_NONE = 4'b0000;
   function automatic onehot_t decode(code_t code, logic en);
      return en ? onehot_t'(4'b0001 << code) : ONEHOT_NONE;
   endfunction
endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: 2-entry valid/ready skid buffer with registered output and ready
import decoder24_pkg::*;
module dec_skid_buf #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   st_t          st;
   logic [W-1:0] skid;
   assign out_valid = st != ST_EMPTY;
   assign in_ready  = st != ST_FULL;
   // in_ready is 1 in EMPTY and ONE, so in_valid alone marks an accept there
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st       <= ST_EMPTY;
         out_data <= '0;
         skid     <= '0;
      end else
         case (st)
            ST_EMPTY: if (in_valid) begin
               out_data <= in_data;
               st       <= ST_ONE;
            end
            ST_ONE:
               if (in_valid && out_ready) out_data <= in_data;
               else if (in_valid) begin
                  skid <= in_data;
                  st   <= ST_FULL;
               end else if (out_ready) st <= ST_EMPTY;
            ST_FULL: if (out_ready) begin
               out_data <= skid;
               st       <= ST_ONE;
            end
            default: st <= ST_EMPTY;
         endcase
endmodule

// File: rtl/decoder24_stream.sv
// decoder24_stream: streaming 2-to-4 one-hot decoder with skid output and saturating line counters
import decoder24_pkg::*;
module decoder24_stream #(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_code,
   input  logic               in_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_onehot,
   input  logic               clr_cnt,
   output logic [4*CNT_W-1:0] cnt_o
);
   onehot_t dec;
   logic    out_xfer;
   assign dec      = decode(in_code, in_en);
   assign out_xfer = out_valid && out_ready;
   dec_skid_buf #(.W(4)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (dec),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_onehot)
   );
   for (genvar i = 0; i < 4; i++) begin : g_cnt
      logic [CNT_W-1:0] c;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) c <= '0;
         else if (clr_cnt) c <= '0;
         else if (out_xfer && out_onehot[i] && c != {CNT_W{1'b1}}) c <= c + 1'b1;
      assign cnt_o[i*CNT_W +: CNT_W] = c;
   end
endmodule

// File: tb/tb_decoder24_stream.sv
// tb_decoder24_stream: table-driven and scoreboard checks of decoder24_stream
module tb_decoder24_stream;
   localparam int CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, in_ready, in_en = 0, out_valid, out_ready = 0, clr_cnt = 0;
   logic [1:0] in_code = 0;
   logic [3:0] out_onehot;
   logic [4*CNT_W-1:0] cnt_o;
   int checks = 0, errors = 0;
   logic [3:0] q[$];
   int mc[4];
   logic [3:0] lut[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   typedef struct {logic [1:0] code; logic en; logic [3:0] exp;} vec_t;
   vec_t tbl[4];

   decoder24_stream #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_onehot(out_onehot), .clr_cnt(clr_cnt), .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [4*CNT_W-1:0] mcnt();
      logic [4*CNT_W-1:0] r = '0;
      for (int i = 0; i < 4; i++) r[i*CNT_W +: CNT_W] = mc[i][CNT_W-1:0];
      return r;
   endfunction

   function automatic logic [3:0] mdec(input logic [1:0] c, input logic e);
      return e ? lut[c] : 4'b0000;
   endfunction

   // called at a negedge: check state, drive inputs, account for the coming posedge
   task automatic step(input logic iv, input logic [1:0] c, input logic e,
                       input logic ordy, input logic clr, input logic full_chk = 1);
      logic [3:0] exp;
      if (full_chk) begin
         chk("out_valid", out_valid, q.size() != 0);
         chk("in_ready", in_ready, q.size() < 2);
         chk("cnt", cnt_o, mcnt());
      end
      in_valid = iv; in_code = iv ? c : 2'bxx; in_en = e; out_ready = ordy; clr_cnt = clr;
      if (iv && in_ready) q.push_back(mdec(c, e));
      if (out_valid && ordy) begin
         exp = q.size() != 0 ? q.pop_front() : 4'bxxxx;
         chk("data", out_onehot, exp);
         if (!clr) for (int i = 0; i < 4; i++) if (exp[i] && mc[i] < CMAX) mc[i]++;
      end
      if (clr) for (int i = 0; i < 4; i++) mc[i] = 0;
      @(negedge clk);
   endtask

   initial begin
      int sent, cyc;
      logic [3:0] snap;
      tbl[0] = '{2'd0, 1'b1, 4'b0001};
      tbl[1] = '{2'd1, 1'b1, 4'b0010};
      tbl[2] = '{2'd2, 1'b1, 4'b0100};
      tbl[3] = '{2'd3, 1'b1, 4'b1000};
      for (int i = 0; i < 4; i++) mc[i] = 0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_onehot", out_onehot, 4'b0000);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cnt", cnt_o, 0);
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      // streaming table with out_ready held high
      for (int i = 0; i < 4; i++) begin
         step(1, tbl[i].code, tbl[i].en, 1, 0);
         chk("tbl_valid", out_valid, 1);
         chk("tbl_onehot", out_onehot, tbl[i].exp);
      end
      step(0, 0, 1, 1, 0);
      chk("tbl_cnt", cnt_o, 8'b01_01_01_01);
      // backpressure: 2 and 3 accepted, 1 refused until space frees
      step(1, 2, 1, 0, 0);
      chk("bp_ready1", in_ready, 1);
      step(1, 3, 1, 0, 0);
      chk("bp_ready_drop", in_ready, 0);
      step(1, 1, 1, 0, 0);
      chk("bp_hold", out_onehot, 4'b0100);
      chk("bp_qsize", q.size(), 2);
      step(1, 1, 1, 1, 0);
      chk("bp_ready_back", in_ready, 1);
      chk("bp_out2", out_onehot, 4'b1000);
      step(1, 1, 1, 1, 0);
      chk("bp_out3", out_onehot, 4'b0010);
      step(0, 0, 1, 1, 0);
      chk("bp_empty", out_valid, 0);
      // disabled token
      snap = 0;
      step(1, 3, 0, 0, 0);
      chk("en0_valid", out_valid, 1);
      chk("en0_onehot", out_onehot, 4'b0000);
      step(0, 0, 1, 1, 0);
      chk("en0_cnt", cnt_o, 8'b10_10_10_01);
      // saturation of line 1, then clear racing an increment
      for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("sat_cnt1", cnt_o[CNT_W +: CNT_W], 2'd3);
      step(1, 1, 1, 1, 0);
      step(0, 0, 1, 1, 1);
      chk("clr_cnt", cnt_o, 0);
      // reset while FULL
      step(1, 2, 1, 0, 0);
      step(1, 3, 1, 0, 0);
      chk("pre_rst_full", in_ready, 0);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_onehot", out_onehot, 4'b0000);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_cnt", cnt_o, 0);
      q.delete();
      for (int i = 0; i < 4; i++) mc[i] = 0;
      in_valid = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      step(1, 0, 1, 1, 0);
      chk("post_rst_onehot", out_onehot, 4'b0001);
      step(0, 0, 1, 1, 0);
      chk("post_rst_only", out_valid, 0);
      // random valid/ready traffic against the scoreboard
      sent = 0; cyc = 0;
      while (sent < 10000 && cyc < 60000) begin
         logic iv;
         iv = $urandom_range(3) != 0;
         if (iv && in_ready) sent++;
         step(iv, 2'($urandom_range(3)), $urandom_range(7) != 0,
              $urandom_range(3) != 0, $urandom_range(15) == 0, (cyc % 8) == 0);
         cyc++;
      end
      chk("rand_sent", sent, 10000);
      cyc = 0;
      while (q.size() != 0 && cyc < 10) begin
         step(0, 0, 1, 1, 0, 0);
         cyc++;
      end
      chk("rand_drain", q.size(), 0);
      chk("rand_cnt", cnt_o, mcnt());
      chk("rand_idle", out_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decoder24_stream.md
# decoder24_stream

Streaming 2-to-4 one-hot decoder: the inverse of the team's 4:2 priority-free encoder, restoring a 2-bit line code to a one-hot 4-bit select. It sits on a valid/ready stream between a code producer and a select consumer. A registered output stage with a skid entry gives full throughput under backpressure. Saturating per-line event counters provide debug visibility.

## Interface
Parameters:
- CNT_W, 8, width of each per-line saturating event counter (2..16)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_code/in_en valid
- in_ready  output  1  block can accept an input this cycle
- in_code  input  2  code to decode (0..3)
- in_en  input  1  1 decodes normally; 0 yields an all-zero output token
- out_valid  output  1  out_onehot valid
- out_ready  input  1  consumer accepts out_onehot this cycle
- out_onehot  output  4  decoded select, held stable while out_valid && !out_ready
- clr_cnt  input  1  synchronous clear of all counters
- cnt_o  output  4*CNT_W  counters; line i at [i*CNT_W +: CNT_W]

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Decode rule: in_en=1 gives out_onehot = 4'b0001 << in_code, so 0→0001, 1→0010, 2→0100, 3→1000. in_en=0 gives 4'b0000. The disabled token is still delivered as a transfer.
- Storage is two entries: an output register (OUT) and a skid register (SKID). State encodings:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Transitions:
  - EMPTY: on accept, go to ONE.
  - ONE, accept with no output transfer: go to FULL, new token into SKID.
  - ONE, output transfer with no accept: go to EMPTY.
  - ONE, both transfer: stay ONE, OUT loads the new token.
  - FULL, output transfer: OUT ← SKID, go to ONE. No accept is possible in FULL.
- in_ready = !SKID.valid. It is registered state, not combinationally dependent on out_ready.
- Ordering is strict FIFO; no token is dropped or duplicated.
- Counters: on each output transfer, cnt[i] increments for every set bit i of out_onehot (at most one). Each counter saturates at 2^CNT_W−1 and does not wrap.
- clr_cnt=1 zeroes all counters that cycle. clr_cnt wins over a simultaneous increment.
- in_code is only sampled on an input transfer; X on in_code while !in_valid must not propagate.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_onehot=4'b0000, in_ready=1.
  - Every counter is 0, SKID is invalid, state is EMPTY.
- Latency: a token accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: one token per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, at most two tokens are accepted.
  - in_ready drops the cycle after the second accept.
  - in_ready reasserts the cycle after the first output transfer from FULL.
- out_onehot changes only on an output transfer or a load into an empty OUT.
- Reset mid-stream discards both entries. Counters reset; there is no partial state.

## Structure
- Package decoder24_pkg holds:
  - typedef code_t (logic [1:0]) and onehot_t (logic [3:0]).
  - typedef enum st_t {ST_EMPTY, ST_ONE, ST_FULL}.
  - Constant ONEHOT_NONE = 4'b0000.
  - Function decode(code_t, logic en) returning onehot_t.
- One sub-module, dec_skid_buf: a 2-entry valid/ready skid buffer parameterized on data width, instantiated with width 4 on the decoded data.
- Decode happens before the buffer. Counters live in the top.

## Test plan
- Reset then stream codes 0,1,2,3 with en=1 and out_ready=1:
  - out_onehot is 0001,0010,0100,1000 on consecutive cycles, first one the cycle after the first accept.
  - cnt_o = {1,1,1,1}.
- Hold out_ready=0 and offer codes 2,3,1:
  - Exactly 2 and 3 accepted, in_ready=0 from the cycle after the second accept.
  - Releasing out_ready yields 0100, 1000, then 0010, with no loss or reordering.
- in_en=0 with code 3:
  - out_valid=1 with out_onehot=0000.
  - All counters unchanged.
- CNT_W=2, send code 1 five times:
  - cnt[1] saturates at 3.
  - Asserting clr_cnt in the same cycle as a code-1 output transfer gives cnt[1]=0.
- Assert rst_n=0 while FULL with out_ready=0:
  - Immediately out_valid=0, out_onehot=0000, in_ready=1, all counters 0.
  - After release, the next accepted code 0 produces 0001 only.
- Random valid/ready toggling, 10k tokens, scoreboard check: output sequence equals decode() of the input sequence, and counters match the scoreboard tallies.
